stopwatch_bcd_core: RTL and testbench
=====================================

Name: stopwatch_bcd_core

Overview:
- Downstream consumer of the free-running 1..50,000,000 cycle counter (26-bit, 50 MHz clk).
- Detects the terminal count as a 1 Hz tick and drives an MM:SS BCD stopwatch (00:00–59:59) with start/pause, clear and lap-hold control.
- Outputs feed the 4-digit seven-segment display driver directly.

Parameters:
- CNT_W, 26, width of incoming counter value.
- TICK_VAL, 50000000, counter value that marks one elapsed second (set to 5 in simulation).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  reset, synchronous, active-high.
- cnt_in  input  CNT_W  current value of upstream 1..TICK_VAL counter.
- start_pause  input  1  single-cycle pulse (already debounced/one-pulsed); toggles run/pause.
- clear  input  1  single-cycle pulse; zero time, stop, release hold.
- lap  input  1  single-cycle pulse; toggles display freeze.
- min_t  output  4  displayed minutes tens, BCD 0..5.
- min_u  output  4  displayed minutes units, BCD 0..9.
- sec_t  output  4  displayed seconds tens, BCD 0..5.
- sec_u  output  4  displayed seconds units, BCD 0..9.
- running  output  1  high in RUN state.
- held  output  1  high while display is frozen.
- tick_1hz  output  1  one-cycle pulse, registered, whenever cnt_in == TICK_VAL (independent of state).
- wrap  output  1  one-cycle pulse when time rolls 59:59 -> 00:00.

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; live time 00:00; snapshot 00:00; all outputs 0; held=0.
- States: IDLE (time 00:00, stopped), RUN, PAUSE.
  - IDLE --start_pause--> RUN; RUN --start_pause--> PAUSE; PAUSE --start_pause--> RUN.
  - Any state --clear--> IDLE.
- Tick: sec_tick = (cnt_in == TICK_VAL), evaluated combinationally; tick_1hz is sec_tick registered (1-cycle latency).
- Time advance: on a posedge with sec_tick=1 and current state RUN, live time increments by one second; new value visible the following cycle.
  - sec_u 9->0 carries to sec_t; sec_t 5->0 carries to min_u; min_u 9->0 carries to min_t; min_t 5 with all lower digits at max -> 00:00, wrap=1 for one cycle.
- Priority, same cycle: rst > clear > tick/start_pause.
  - Tick and start_pause together: tick uses the pre-transition state. RUN+pause still counts that second; PAUSE/IDLE+start does not.
  - clear with tick: time 00:00, no increment, no wrap.
- Lap hold:
  - lap with held=0: snapshot <= live time (value before any same-cycle increment); held=1.
  - lap with held=1: held=0.
  - Display outputs = snapshot when held, else live time.
  - Live time keeps counting while held.
  - clear forces held=0.
- running is registered: equals (state==RUN).
- cnt_in values outside 1..TICK_VAL only matter through the equality compare; no other checks.
- Digits never hold non-BCD values; no illegal state is reachable. An illegal state encoding recovers to IDLE.

Decomposition:
- Shared package: TICK_VAL and CNT_W defaults, state encoding constants (IDLE/RUN/PAUSE), BCD max constants (9, 5).
- Sub-module bcd_digit_cnt (parameter MAX; inputs clk, rst, clr, inc; outputs digit[3:0], carry). carry is combinational = inc && digit==MAX.
- Instantiate four bcd_digit_cnt in a carry chain.

Test Plan (TICK_VAL=5):
- Reset, then start_pause pulse, drive cnt_in cycling 1..5 for 12 ticks -> live display 00:12, running=1, tick_1hz pulses 12 times one cycle after each cnt_in==5.
- Preload by running to 00:59, one more tick -> 01:00. Continue to 59:59, one more tick -> 00:00 with wrap=1 for exactly one cycle.
- At 00:07 in RUN, assert start_pause in the same cycle as cnt_in==5 -> display 00:08, state PAUSE. Further ticks leave 00:08, running=0.
- At 00:03 in PAUSE, start_pause coincident with tick -> stays 00:03 that cycle, running=1, next tick -> 00:04.
- At 00:10 RUN, lap -> held=1, display frozen 00:10. After 5 ticks lap again -> held=0, display 00:15.
- At 00:20 RUN with held=1, clear coincident with tick and start_pause -> display 00:00, held=0, running=0, wrap=0. rst pulse mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/stopwatch_bcd_core_pkg.sv
// Shared constants for the MM:SS stopwatch: tick defaults, FSM encoding, BCD limits.
package stopwatch_bcd_core_pkg;
  localparam int CNT_W_DEF    = 26;
  localparam int TICK_VAL_DEF = 50000000;
  localparam int NUM_DIGITS   = 4;
  localparam int BCD_MAX9     = 9;
  localparam int BCD_MAX5     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  // Digit order in packed time vectors: [0]=sec_u, [1]=sec_t, [2]=min_u, [3]=min_t
  function automatic int digit_max(input int idx);
    return (idx % 2 == 0) ? BCD_MAX9 : BCD_MAX5;
  endfunction
endpackage

// File: rtl/stopwatch_bcd_core_bcd_digit_cnt.sv
// One BCD digit counting 0..MAX; carry fires combinationally on the rollover increment.
module bcd_digit_cnt #(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);
  localparam logic [3:0] MAX_D = 4'(MAX);

  assign carry = inc && (digit == MAX_D);

  always_ff @(posedge clk) begin
    if (rst || clr)
      digit <= '0;
    else if (digit > MAX_D)
      digit <= '0;                 // out-of-range value self-heals to zero
    else if (inc)
      digit <= (digit == MAX_D) ? '0 : digit + 4'd1;
  end
endmodule

// File: rtl/stopwatch_bcd_core.sv
// MM:SS BCD stopwatch driven by the upstream 1..TICK_VAL cycle counter, with run/pause, clear and lap hold.
module stopwatch_bcd_core
  import stopwatch_bcd_core_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TICK_VAL = TICK_VAL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             start_pause,
  input  logic             clear,
  input  logic             lap,
  output logic [3:0]       min_t,
  output logic [3:0]       min_u,
  output logic [3:0]       sec_t,
  output logic [3:0]       sec_u,
  output logic             running,
  output logic             held,
  output logic             tick_1hz,
  output logic             wrap
);
  sw_state_e                        state;
  logic                             sec_tick;
  logic [NUM_DIGITS-1:0]            inc;
  logic [NUM_DIGITS-1:0]            carry;
  logic [NUM_DIGITS-1:0][3:0]       live;
  logic [NUM_DIGITS-1:0][3:0]       snap;
  logic [NUM_DIGITS-1:0][3:0]       disp;

  assign sec_tick = (cnt_in == CNT_W'(TICK_VAL));
  // Pre-transition state decides whether this second counts; clear suppresses it.
  assign inc[0]   = sec_tick && (state == ST_RUN) && !clear;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    if (i > 0) begin : g_chain
      assign inc[i] = carry[i-1];
    end
    bcd_digit_cnt #(.MAX(digit_max(i))) u_dig (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (inc[i]),
      .digit (live[i]),
      .carry (carry[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      running  <= 1'b0;
      held     <= 1'b0;
      snap     <= '0;
      tick_1hz <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      tick_1hz <= sec_tick;
      wrap     <= carry[NUM_DIGITS-1];
      if (clear) begin
        state   <= ST_IDLE;
        running <= 1'b0;
        held    <= 1'b0;
      end else begin
        if (lap) begin
          if (!held) snap <= live;   // captures value before any same-cycle increment
          held <= !held;
        end
        case (state)
          ST_IDLE, ST_PAUSE: if (start_pause) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
          ST_RUN: if (start_pause) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end
          default: begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign disp  = held ? snap : live;
  assign sec_u = disp[0];
  assign sec_t = disp[1];
  assign min_u = disp[2];
  assign min_t = disp[3];
endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Directed bench: a seconds-based reference model pushes expected outputs to a scoreboard each cycle.
module tb_stopwatch_bcd_core;
  localparam int CNT_W = 26;
  localparam int TV    = 5;

  logic             clk = 1'b0;
  logic             rst, start_pause, clear, lap;
  logic [CNT_W-1:0] cnt_in;
  logic [3:0]       min_t, min_u, sec_t, sec_u;
  logic             running, held, tick_1hz, wrap;

  stopwatch_bcd_core #(.CNT_W(CNT_W), .TICK_VAL(TV)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .start_pause(start_pause),
    .clear(clear), .lap(lap), .min_t(min_t), .min_u(min_u), .sec_t(sec_t),
    .sec_u(sec_u), .running(running), .held(held), .tick_1hz(tick_1hz), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Reference model: time kept as plain seconds, converted to BCD only for comparison.
  int          m_secs, m_snap, m_st;   // m_st: 0 idle, 1 run, 2 pause
  bit          m_held;
  logic [19:0] exp_q[$];
  int          checks = 0, errors = 0;
  int          cnt_ph = 0;
  int          tick_seen = 0, wrap_seen = 0;
  string       tag = "init";

  function automatic logic [15:0] to_bcd(input int s);
    int m, sc;
    m  = s / 60;
    sc = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic cyc(input int c, input bit sp, input bit cl, input bit lp, input bit r);
    logic [19:0] exp_v, obs_v;
    bit tk, wr;
    cnt_in = CNT_W'(c); start_pause = sp; clear = cl; lap = lp; rst = r;
    tk = (c == TV);
    wr = 1'b0;
    if (r) begin
      m_st = 0; m_secs = 0; m_snap = 0; m_held = 0; tk = 0;
    end else if (cl) begin
      m_st = 0; m_secs = 0; m_held = 0;
    end else begin
      if (lp) begin
        if (!m_held) m_snap = m_secs;
        m_held = !m_held;
      end
      if (tk && m_st == 1) begin
        m_secs++;
        if (m_secs == 3600) begin m_secs = 0; wr = 1'b1; end
      end
      if (sp) m_st = (m_st == 1) ? 2 : 1;
    end
    exp_q.push_back({to_bcd(m_held ? m_snap : m_secs), m_st == 1, m_held, tk, wr});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    obs_v = {min_t, min_u, sec_t, sec_u, running, held, tick_1hz, wrap};
    tick_seen += int'(tick_1hz);
    wrap_seen += int'(wrap);
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs_v, exp_v);
    end
  endtask

  // Advance the free-running counter up to its terminal value, applying pulses on the tick cycle.
  task automatic tick_with(input bit sp, input bit cl, input bit lp);
    while (cnt_ph != TV - 1) begin
      cnt_ph = (cnt_ph >= TV) ? 1 : cnt_ph + 1;
      cyc(cnt_ph, 0, 0, 0, 0);
    end
    cnt_ph = TV;
    cyc(TV, sp, cl, lp, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_with(0, 0, 0);
  endtask

  // Control pulse on a non-tick cycle (0 never matches the terminal value).
  task automatic pulse(input bit sp, input bit cl, input bit lp);
    cyc(0, sp, cl, lp, 0);
  endtask

  task automatic check_int(input string t, input int obs, input int exp_i);
    checks++;
    assert (obs === exp_i) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", t, obs, exp_i);
    end
  endtask

  initial begin
    m_secs = 0; m_snap = 0; m_st = 0; m_held = 0;
    tag = "reset";
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    tag = "count12";
    pulse(1, 0, 0);
    tick_seen = 0;
    ticks(12);
    cyc(1, 0, 0, 0, 0);
    cnt_ph = 1;
    check_int("tick_pulses", tick_seen, 12);

    tag = "carry_wrap";
    ticks(59 - 12);
    ticks(1);
    wrap_seen = 0;
    ticks(3599 - 60);
    ticks(1);
    pulse(0, 0, 0);
    check_int("wrap_pulses", wrap_seen, 1);

    tag = "run_pause_tick";
    ticks(7);
    tick_with(1, 0, 0);
    ticks(3);

    tag = "pause_start_tick";
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    ticks(3);
    pulse(1, 0, 0);
    tick_with(1, 0, 0);
    ticks(1);

    tag = "lap_hold";
    ticks(6);
    pulse(0, 0, 1);
    ticks(5);
    pulse(0, 0, 1);

    tag = "clear_all";
    ticks(5);
    pulse(0, 0, 1);
    tick_with(1, 1, 0);
    pulse(0, 0, 0);

    tag = "lap_on_tick";
    pulse(1, 0, 0);
    ticks(2);
    tick_with(0, 0, 1);
    ticks(2);

    tag = "rst_mid_run";
    cyc(3, 0, 0, 0, 1);
    pulse(0, 0, 0);
    cnt_ph = 0;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
